// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with a registered one-hot grant held until done.
// Optional grant watchdog is built when ARB_TIMEOUT_EN is defined.
module rr_arbiter8 #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rr_arbiter8: TIMEOUT_CYCLES must be in 2..255");
  end

  state_e             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic               gnt_valid_q;
  logic               timeout_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic [IDX_W-1:0]   gnt_idx_d;
  logic [IDX_W-1:0]   scan_idx;
  logic               found;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]   cnt_q;
`endif

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    gnt_idx_d = '0;
    scan_idx  = '0;
    found     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = ptr_q + IDX_W'(i);
      if (!found && req[scan_idx]) begin
        gnt_idx_d = scan_idx;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q     <= GRANT;
            gnt_q       <= N_REQ'(1) << gnt_idx_d;
            gnt_valid_q <= 1'b1;
            gnt_idx_q   <= gnt_idx_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        GRANT: begin
          if (done) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= gnt_idx_q + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
          end else if (cnt_q == CNT_LAST) begin
            // Watchdog release: identical to done, plus a one-cycle flag.
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= gnt_idx_q + IDX_W'(1);
            timeout_q   <= 1'b1;
          end else begin
            cnt_q       <= cnt_q + CNT_W'(1);
`endif
          end
        end
        default: begin
          state_q     <= IDLE;
          gnt_q       <= '0;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: vector table plus rotation and watchdog sequences,
// expectations queued at drive time and popped after each clock edge.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       to;
  } vec_t;

  typedef struct {
    logic [7:0] gnt;
    logic       to;
    string      tag;
  } exp_t;

  exp_t sb[$];

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  rr_arbiter8 #(.TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, expv);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic d,
                      input logic [7:0] eg, input logic et, input string tag);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = d;
    sb.push_back('{gnt: eg, to: et, tag: tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".gnt"}, gnt, e.gnt);
    check({e.tag, ".gnt_valid"}, {7'b0, gnt_valid}, {7'b0, |e.gnt});
    check({e.tag, ".timeout"}, {7'b0, timeout}, {7'b0, e.to});
  endtask

  initial begin
    logic [7:0] one;
    logic [7:0] eg;
    logic       et;
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    one  = 8'h01;

    vecs[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 8'h24, 1'b0, 8'h04, 1'b0};
    vecs[8]  = '{1'b0, 8'h24, 1'b1, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 8'h24, 1'b0, 8'h20, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h20, 1'b0};
    vecs[11] = '{1'b0, 8'hFF, 1'b1, 8'h00, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[13] = '{1'b0, 8'h81, 1'b0, 8'h80, 1'b0};
    vecs[14] = '{1'b0, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 8'h80, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[17] = '{1'b0, 8'hFF, 1'b0, 8'h01, 1'b0};
    vecs[18] = '{1'b0, 8'hFF, 1'b1, 8'h00, 1'b0};
    vecs[19] = '{1'b0, 8'hFF, 1'b0, 8'h02, 1'b0};
    vecs[20] = '{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0};
    vecs[21] = '{1'b0, 8'hFF, 1'b0, 8'h01, 1'b0};
    vecs[22] = '{1'b0, 8'h00, 1'b0, 8'h01, 1'b0};
    vecs[23] = '{1'b0, 8'h10, 1'b1, 8'h00, 1'b0};
    vecs[24] = '{1'b0, 8'h11, 1'b0, 8'h10, 1'b0};
    vecs[25] = '{1'b0, 8'h11, 1'b1, 8'h00, 1'b0};

    for (int i = 0; i < NVEC; i++)
      step(vecs[i].rst, vecs[i].req, vecs[i].done, vecs[i].gnt, vecs[i].to,
           $sformatf("vec%0d", i));

    // Full rotation from reset: 01,00,02,00,...,80,00,01.
    step(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, "rot_rst");
    for (int k = 0; k < 9; k++) begin
      eg = one << (k % 8);
      step(1'b0, 8'hFF, 1'b0, eg, 1'b0, $sformatf("rot_g%0d", k));
      step(1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, $sformatf("rot_r%0d", k));
    end

    // Grant held with done low: watchdog release only when built in.
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, "wd_rst");
    step(1'b0, 8'h02, 1'b0, 8'h02, 1'b0, "wd_g0");
    for (int j = 1; j < 16; j++)
      step(1'b0, 8'h02, 1'b0, 8'h02, 1'b0, $sformatf("wd_g%0d", j));
`ifdef ARB_TIMEOUT_EN
    eg = 8'h00;
    et = 1'b1;
`else
    eg = 8'h02;
    et = 1'b0;
`endif
    step(1'b0, 8'h00, 1'b0, eg, et, "wd_expire");
    step(1'b0, 8'h00, 1'b0, eg, 1'b0, "wd_after");
    step(1'b0, 8'h00, 1'b0, eg, 1'b0, "wd_after2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, grant watchdog limit in clock cycles; legal range 2..255; used only when ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  8  request lines; bit i = requester i; any number may be high at once.
REQ-005 done  input  1  holder of the current grant releases it; sampled only in GRANT.
REQ-006 gnt  output  8  registered grant vector, one-hot or all-zero; drives the downstream 8-to-3 encoder.
REQ-007 gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-008 timeout  output  1  one-cycle pulse on watchdog release; constant 0 when ARB_TIMEOUT_EN is undefined.

Function
REQ-009 State machine has two states: IDLE (gnt=0) and GRANT (gnt one-hot).
REQ-010 A 3-bit pointer ptr holds the highest-priority index; priority order is ptr, ptr+1, ..., ptr+7, mod 8.
REQ-011 In IDLE, if req != 0 at a rising edge, gnt takes the one-hot of the first set bit of req in priority order, and state becomes GRANT; latency from req sampled to gnt visible is one cycle.
REQ-012 In IDLE with req == 0, gnt stays 0 and ptr is unchanged.
REQ-013 In GRANT, gnt holds its value regardless of req changes, including deassertion of the granted bit.
REQ-014 In GRANT, done=1 at a rising edge clears gnt to 0, returns to IDLE and sets ptr = granted index + 1 (7 wraps to 0).
REQ-015 After a release there is always at least one IDLE cycle with gnt=0 before the next grant; back-to-back grants are separated by exactly one cycle when req is continuously non-zero.
REQ-016 done in IDLE is ignored.
REQ-017 gnt never has more than one bit set; gnt_valid equals OR-reduction of gnt and is registered with it.
REQ-018 With all eight req bits held high and done pulsed once per grant, grants rotate 0,1,2,...,7,0 (after reset).

Reset
REQ-019 While rst=1 at a rising edge: state=IDLE, gnt=8'h00, gnt_valid=0, timeout=0, ptr=0, watchdog counter=0.
REQ-020 rst takes priority over done, req and watchdog expiry in the same cycle; a grant in progress is dropped without a timeout pulse.
REQ-021 First grant is possible at the first rising edge after rst is sampled low.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN: when defined, a counter clears on entry to GRANT and increments each GRANT cycle without done; when it reaches TIMEOUT_CYCLES-1 with done=0, the next edge releases exactly as REQ-014 and timeout pulses high for that one cycle.
REQ-023 If done and expiry coincide, the release is a normal release and timeout stays 0.
REQ-024 When ARB_TIMEOUT_EN is undefined, no counter is built, grants are held indefinitely until done, and timeout is tied to 0.

Verification
REQ-025 rst high 2 cycles, then req=8'h00 for 5 cycles -> gnt=8'h00, gnt_valid=0 throughout.
REQ-026 After reset, req=8'h24 -> next cycle gnt=8'h04; done pulse -> gnt=8'h00 one cycle, then gnt=8'h20 (ptr=3).
REQ-027 req=8'hFF held, done pulsed each GRANT cycle -> gnt sequence 01,00,02,00,04,...,80,00,01 (wrap).
REQ-028 Grant to bit 7 held, req[7] dropped while done=0 -> gnt stays 8'h80 until done; rst asserted mid-grant -> gnt=8'h00, next grant for req=8'hFF is 8'h01.
REQ-029 With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, req=8'h02, done never asserted -> gnt=8'h02 for 16 cycles, then gnt=8'h00 with timeout=1 for one cycle; without the macro gnt=8'h02 indefinitely, timeout=0.
